// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between a DMA and a host requester.
// Round-robin on ties, a per-grant burst limit, and a two-stage pipeline that
// returns each beat's ack (and read data) two cycles after the beat edge.
module ram_arbiter #(
   parameter int unsigned MAX_BURST = 8,
   localparam int unsigned ADDR_W = 64,
   localparam int unsigned DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              dma_req,
   input  logic              dma_write,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   input  logic              host_req,
   input  logic              host_write,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_out,
   output logic              ram_write,
   output logic              ram_read,
   input  logic [DATA_W-1:0] ram_data_in,
   output logic              busy
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT_DMA  = 2'd1,
      GNT_HOST = 2'd2
   } state_t;

   typedef enum logic {
      SRC_DMA  = 1'b0,
      SRC_HOST = 1'b1
   } src_t;

   // One in-flight beat travelling towards its ack
   typedef struct packed {
      logic valid;
      logic to_host;
      logic is_read;
   } ack_tag_t;

   state_t            state_q, state_d;
   src_t              last_served_q, last_served_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [DATA_W-1:0] ram_data_out_q, ram_data_out_d;
   logic              ram_write_q, ram_write_d;
   logic              ram_read_q, ram_read_d;
   ack_tag_t          tag1_q, tag1_d;
   ack_tag_t          tag2_q, tag2_d;
   logic              dma_ack_q, dma_ack_d;
   logic              host_ack_q, host_ack_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
   logic              dma_gnt_q, dma_gnt_d;
   logic              host_gnt_q, host_gnt_d;
   logic              busy_q, busy_d;

   src_t              cur_src;
   logic              cur_req;
   logic              oth_req;
   logic              cur_write;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;

   // Select the request fields of whoever currently holds the grant
   always_comb begin
      if (state_q == GNT_HOST) begin
         cur_src   = SRC_HOST;
         cur_req   = host_req;
         oth_req   = dma_req;
         cur_write = host_write;
         cur_addr  = host_addr;
         cur_wdata = host_wdata;
      end else begin
         cur_src   = SRC_DMA;
         cur_req   = dma_req;
         oth_req   = host_req;
         cur_write = dma_write;
         cur_addr  = dma_addr;
         cur_wdata = dma_wdata;
      end
   end

   // Arbitration, beat issue and burst-limit release
   always_comb begin
      state_d        = state_q;
      last_served_d  = last_served_q;
      beat_cnt_d     = beat_cnt_q;
      ram_address_d  = ram_address_q;
      ram_data_out_d = ram_data_out_q;
      ram_write_d    = 1'b0;
      ram_read_d     = 1'b0;
      tag1_d         = '0;
      tag2_d         = tag1_q;

      case (state_q)
         IDLE: begin
            if (dma_req && host_req) begin
               state_d = (last_served_q == SRC_DMA) ? GNT_HOST : GNT_DMA;
            end else if (dma_req) begin
               state_d = GNT_DMA;
            end else if (host_req) begin
               state_d = GNT_HOST;
            end
         end

         GNT_DMA, GNT_HOST: begin
            if (cur_req) begin
               ram_address_d  = cur_addr & WORD_MASK;
               ram_data_out_d = cur_wdata;
               ram_write_d    = cur_write;
               ram_read_d     = ~cur_write;
               tag1_d.valid   = 1'b1;
               tag1_d.to_host = (cur_src == SRC_HOST);
               tag1_d.is_read = ~cur_write;
            end

            // Release on a dropped request or on the final beat of a burst
            if (!cur_req || (beat_cnt_q == LAST_BEAT)) begin
               last_served_d = cur_src;
               beat_cnt_d    = '0;
               if (oth_req) begin
                  state_d = (state_q == GNT_DMA) ? GNT_HOST : GNT_DMA;
               end else if (!cur_req) begin
                  state_d = IDLE;
               end
            end else begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Ack delivery and read-data capture at the end of the pipeline
   always_comb begin
      dma_ack_d    = tag2_q.valid & ~tag2_q.to_host;
      host_ack_d   = tag2_q.valid &  tag2_q.to_host;
      dma_rdata_d  = (dma_ack_d  && tag2_q.is_read) ? ram_data_in : dma_rdata_q;
      host_rdata_d = (host_ack_d && tag2_q.is_read) ? ram_data_in : host_rdata_q;
   end

   // Grant and busy flags follow the next state so they change with it
   always_comb begin
      dma_gnt_d  = (state_d == GNT_DMA);
      host_gnt_d = (state_d == GNT_HOST);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q        <= IDLE;
         last_served_q  <= SRC_HOST;
         beat_cnt_q     <= '0;
         ram_address_q  <= '0;
         ram_data_out_q <= '0;
         ram_write_q    <= 1'b0;
         ram_read_q     <= 1'b0;
         tag1_q         <= '0;
         tag2_q         <= '0;
         dma_ack_q      <= 1'b0;
         host_ack_q     <= 1'b0;
         dma_rdata_q    <= '0;
         host_rdata_q   <= '0;
         dma_gnt_q      <= 1'b0;
         host_gnt_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_served_q  <= last_served_d;
         beat_cnt_q     <= beat_cnt_d;
         ram_address_q  <= ram_address_d;
         ram_data_out_q <= ram_data_out_d;
         ram_write_q    <= ram_write_d;
         ram_read_q     <= ram_read_d;
         tag1_q         <= tag1_d;
         tag2_q         <= tag2_d;
         dma_ack_q      <= dma_ack_d;
         host_ack_q     <= host_ack_d;
         dma_rdata_q    <= dma_rdata_d;
         host_rdata_q   <= host_rdata_d;
         dma_gnt_q      <= dma_gnt_d;
         host_gnt_q     <= host_gnt_d;
         busy_q         <= busy_d;
      end
   end

   assign dma_gnt      = dma_gnt_q;
   assign host_gnt     = host_gnt_q;
   assign busy         = busy_q;
   assign dma_ack      = dma_ack_q;
   assign host_ack     = host_ack_q;
   assign dma_rdata    = dma_rdata_q;
   assign host_rdata   = host_rdata_q;
   assign ram_address  = ram_address_q;
   assign ram_data_out = ram_data_out_q;
   assign ram_write    = ram_write_q;
   assign ram_read     = ram_read_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scenario tasks plus randomized traffic, each cycle compared
// against a transaction-level reference (owner/burst counters, ack event queue,
// shadow memory) and a behavioural RAM that answers reads one cycle late.
module tb_ram_arbiter;

   localparam int unsigned MB = 8;
   localparam int unsigned VW = 167;

   logic        CLK;
   logic        RESET;
   logic        dma_req, dma_write;
   logic [63:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_gnt, dma_ack;
   logic [31:0] dma_rdata;
   logic        host_req, host_write;
   logic [63:0] host_addr;
   logic [31:0] host_wdata;
   logic        host_gnt, host_ack;
   logic [31:0] host_rdata;
   logic [63:0] ram_address;
   logic [31:0] ram_data_out;
   logic        ram_write, ram_read;
   logic [31:0] ram_data_in;
   logic        busy;

   ram_arbiter #(.MAX_BURST(MB)) dut (
      .CLK(CLK), .RESET(RESET),
      .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .host_req(host_req), .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_ack(host_ack), .host_rdata(host_rdata),
      .ram_address(ram_address), .ram_data_out(ram_data_out),
      .ram_write(ram_write), .ram_read(ram_read), .ram_data_in(ram_data_in),
      .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   typedef struct {
      int          due;
      bit          to_dma;
      bit          rd;
      logic [31:0] data;
   } ack_ev_t;

   ack_ev_t     ack_q[$];
   int          m_cyc  = 0;
   int          m_own  = 0;   // 0 none, 1 dma, 2 host
   int          m_last = 2;
   int          m_beats = 0;
   logic [63:0] e_addr  = '0;
   logic [31:0] e_wdata = '0;
   bit          e_wr = 0, e_rd = 0, e_dack = 0, e_hack = 0;
   logic [31:0] e_drd = '0, e_hrd = '0;
   logic [VW-1:0] exp_vec = '0;

   logic [31:0] ref_mem [logic [63:0]];
   logic [31:0] ram_mem [logic [63:0]];
   bit          rsp_pend = 0;
   logic [31:0] rsp_data = '0;

   function automatic logic [31:0] mem_init(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [VW-1:0] out_vec();
      return {dma_gnt, host_gnt, busy, ram_write, ram_read, dma_ack, host_ack,
              ram_address, ram_data_out, dma_rdata, host_rdata};
   endfunction

   // Apply one rising edge of the arbitration rules to the reference model
   task automatic model_edge();
      ack_ev_t     ev;
      bit          r, o, w;
      logic [63:0] a;
      logic [31:0] wd;
      m_cyc++;
      if (RESET) begin
         m_own = 0; m_last = 2; m_beats = 0;
         e_addr = '0; e_wdata = '0; e_wr = 0; e_rd = 0; e_dack = 0; e_hack = 0;
         e_drd = '0; e_hrd = '0;
         ack_q.delete();
      end else begin
         e_wr = 0; e_rd = 0; e_dack = 0; e_hack = 0;
         while (ack_q.size() > 0 && ack_q[0].due == m_cyc) begin
            ev = ack_q.pop_front();
            if (ev.to_dma) begin e_dack = 1; if (ev.rd) e_drd = ev.data; end
            else begin e_hack = 1; if (ev.rd) e_hrd = ev.data; end
         end
         if (m_own == 0) begin
            if (dma_req && host_req) m_own = (m_last == 1) ? 2 : 1;
            else if (dma_req)        m_own = 1;
            else if (host_req)       m_own = 2;
         end else begin
            r  = (m_own == 1) ? dma_req   : host_req;
            o  = (m_own == 1) ? host_req  : dma_req;
            w  = (m_own == 1) ? dma_write : host_write;
            a  = (m_own == 1) ? dma_addr  : host_addr;
            wd = (m_own == 1) ? dma_wdata : host_wdata;
            if (r) begin
               e_addr = {a[63:2], 2'b00}; e_wdata = wd; e_wr = w; e_rd = !w;
               ev.due = m_cyc + 2; ev.to_dma = (m_own == 1); ev.rd = !w;
               ev.data = ref_mem.exists(e_addr) ? ref_mem[e_addr] : mem_init(e_addr);
               if (w) ref_mem[e_addr] = wd;
               ack_q.push_back(ev);
               m_beats++;
            end
            if (!r || m_beats == int'(MB)) begin
               m_last = m_own; m_beats = 0;
               m_own = o ? (3 - m_own) : (r ? m_own : 0);
            end
         end
      end
      exp_vec = {m_own == 1, m_own == 2, m_own != 0, e_wr, e_rd, e_dack, e_hack,
                 e_addr, e_wdata, e_drd, e_hrd};
   endtask

   // Advance one clock, update the model, then service the behavioural RAM
   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      ram_data_in = rsp_pend ? rsp_data : 32'($urandom);
      if (ram_write === 1'b1) ram_mem[ram_address] = ram_data_out;
      rsp_pend = (ram_read === 1'b1);
      if (rsp_pend) rsp_data = ram_mem.exists(ram_address) ? ram_mem[ram_address] : mem_init(ram_address);
   endtask

   task automatic test_reset();
      RESET = 1; dma_req = 0; host_req = 0;
      step(); step();
      n_cmp++;
      if (out_vec() !== exp_vec) begin n_bad++; $display("FAIL reset_model: got %h expected %h", out_vec(), exp_vec); end
      n_cmp++;
      if (out_vec() !== '0) begin n_bad++; $display("FAIL reset_values: got %h expected 0", out_vec()); end
      RESET = 0;
   endtask

   task automatic test_dma_write_burst();
      int wr_cyc[$];
      int ack_cyc[$];
      dma_req = 1; dma_write = 1; dma_addr = 64'd0; dma_wdata = 32'd4; host_req = 0;
      step();
      n_cmp++;
      if (dma_gnt !== 1'b1 || host_gnt !== 1'b0) begin n_bad++; $display("FAIL dma_gnt_latency: got %b expected 1", dma_gnt); end
      for (int i = 0; i < 10; i++) begin
         if (i < 3) begin dma_addr = 64'(4 * i); dma_wdata = 32'(4 * (i + 1)); end
         else dma_req = 0;
         step();
         n_cmp++;
         if (out_vec() !== exp_vec) begin n_bad++; $display("FAIL model_dma_write cyc %0d: got %h expected %h", m_cyc, out_vec(), exp_vec); end
         if (ram_write === 1'b1) begin
            n_cmp++;
            if (ram_address !== 64'(4 * wr_cyc.size()) || ram_data_out !== 32'(4 * (wr_cyc.size() + 1)) || ram_read !== 1'b0) begin
               n_bad++; $display("FAIL dma_write_beat: got addr %h data %h expected addr %h data %h",
                                 ram_address, ram_data_out, 64'(4 * wr_cyc.size()), 32'(4 * (wr_cyc.size() + 1)));
            end
            wr_cyc.push_back(m_cyc);
         end
         if (dma_ack === 1'b1) ack_cyc.push_back(m_cyc);
      end
      n_cmp++;
      if (wr_cyc.size() != 3 || ack_cyc.size() != 3) begin
         n_bad++; $display("FAIL dma_write_counts: got %0d writes %0d acks expected 3 and 3", wr_cyc.size(), ack_cyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ack_cyc[k] - wr_cyc[k] != 2) begin n_bad++; $display("FAIL dma_ack_delay: got %0d expected 2", ack_cyc[k] - wr_cyc[k]); end
         end
      end
   endtask

   task automatic test_host_read();
      ram_mem[64'd512] = 32'h0000_0010; ref_mem[64'd512] = 32'h0000_0010;
      host_req = 1; host_write = 0; host_addr = 64'd512; host_wdata = $urandom; dma_req = 0;
      step();
      step();
      n_cmp++;
      if (ram_read !== 1'b1 || ram_write !== 1'b0 || ram_address !== 64'd512) begin
         n_bad++; $display("FAIL host_read_beat: got rd %b wr %b addr %h expected 1 0 200", ram_read, ram_write, ram_address);
      end
      host_req = 0;
      step();
      n_cmp++;
      if (ram_read !== 1'b0 || host_ack !== 1'b0) begin n_bad++; $display("FAIL host_read_pulse: got rd %b ack %b expected 0 0", ram_read, host_ack); end
      step();
      n_cmp++;
      if (host_ack !== 1'b1 || host_rdata !== 32'h0000_0010 || dma_ack !== 1'b0) begin
         n_bad++; $display("FAIL host_read_ack: got ack %b data %h expected 1 00000010", host_ack, host_rdata);
      end
      step();
      n_cmp++;
      if (out_vec() !== exp_vec || host_ack !== 1'b0 || host_rdata !== 32'h0000_0010) begin
         n_bad++; $display("FAIL host_read_hold: got %h expected %h", out_vec(), exp_vec);
      end
   endtask

   task automatic test_tie_handover();
      RESET = 1; step(); RESET = 0;
      dma_req = 1; dma_write = 1; dma_addr = 64'h100; dma_wdata = $urandom;
      host_req = 1; host_write = 0; host_addr = 64'h200;
      step();
      n_cmp++;
      if (dma_gnt !== 1'b1 || host_gnt !== 1'b0) begin n_bad++; $display("FAIL tie_first_dma: got dma %b host %b expected 1 0", dma_gnt, host_gnt); end
      step();
      dma_req = 0;
      step();
      n_cmp++;
      if (host_gnt !== 1'b1 || dma_gnt !== 1'b0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL handover_no_bubble: got dma %b host %b busy %b expected 0 1 1", dma_gnt, host_gnt, busy);
      end
      for (int i = 0; i < 8; i++) begin
         host_addr = 64'($urandom_range(0, 63) * 4);
         if (i == 3) host_req = 0;
         step();
         n_cmp++;
         if (out_vec() !== exp_vec) begin n_bad++; $display("FAIL model_handover cyc %0d: got %h expected %h", m_cyc, out_vec(), exp_vec); end
      end
   endtask

   task automatic test_burst_fairness();
      int runs_own[$];
      int runs_len[$];
      int cur_own = -1;
      int run_len = 0;
      int own_now;
      int idle_seen = 0;
      RESET = 1; step(); RESET = 0;
      dma_req = 1; host_req = 1; dma_write = 1; host_write = 1;
      for (int i = 0; i < 40; i++) begin
         dma_addr = 64'($urandom_range(0, 255)); dma_wdata = $urandom;
         host_addr = 64'($urandom_range(0, 255)); host_wdata = $urandom;
         step();
         n_cmp++;
         if (out_vec() !== exp_vec) begin n_bad++; $display("FAIL model_fairness cyc %0d: got %h expected %h", m_cyc, out_vec(), exp_vec); end
         own_now = (dma_gnt === 1'b1) ? 1 : ((host_gnt === 1'b1) ? 2 : 0);
         if (busy !== 1'b1) idle_seen++;
         if (own_now == cur_own) run_len++;
         else begin
            if (run_len > 0) begin runs_own.push_back(cur_own); runs_len.push_back(run_len); end
            cur_own = own_now; run_len = 1;
         end
      end
      n_cmp++;
      if (idle_seen != 0 || runs_len.size() < 4) begin
         n_bad++; $display("FAIL fairness_runs: got %0d idle cycles %0d runs expected 0 and >=4", idle_seen, runs_len.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (runs_len[k] != int'(MB) || runs_own[k] != ((k % 2 == 0) ? 1 : 2)) begin
               n_bad++; $display("FAIL burst_limit run %0d: got owner %0d len %0d expected owner %0d len %0d",
                                 k, runs_own[k], runs_len[k], (k % 2 == 0) ? 1 : 2, MB);
            end
         end
      end
      dma_req = 0; host_req = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (out_vec() !== exp_vec) begin n_bad++; $display("FAIL model_fairness_drain cyc %0d: got %h expected %h", m_cyc, out_vec(), exp_vec); end
      end
   endtask

   task automatic test_misaligned();
      dma_req = 1; dma_write = 0; dma_addr = 64'h0000_0000_0000_0207; host_req = 0;
      step();
      step();
      n_cmp++;
      if (ram_address !== 64'h0000_0000_0000_0204 || ram_read !== 1'b1) begin
         n_bad++; $display("FAIL misaligned_addr: got %h expected 0000000000000204", ram_address);
      end
      dma_req = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (out_vec() !== exp_vec) begin n_bad++; $display("FAIL model_misaligned cyc %0d: got %h expected %h", m_cyc, out_vec(), exp_vec); end
      end
   endtask

   task automatic test_reset_midburst();
      host_req = 1; host_write = 0; host_addr = 64'h300; dma_req = 0;
      step();
      step();
      n_cmp++;
      if (ram_read !== 1'b1 || host_gnt !== 1'b1) begin n_bad++; $display("FAIL midburst_beat: got rd %b gnt %b expected 1 1", ram_read, host_gnt); end
      RESET = 1; host_req = 0;
      step();
      n_cmp++;
      if (out_vec() !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL midburst_reset_values: got %h expected 0", out_vec()); end
      RESET = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (host_ack !== 1'b0 || ram_read !== 1'b0 || ram_write !== 1'b0 || out_vec() !== exp_vec) begin
            n_bad++; $display("FAIL midburst_no_ack: got ack %b rd %b wr %b expected 0 0 0", host_ack, ram_read, ram_write);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         RESET      = ($urandom_range(0, 99) < 2);
         dma_req    = ($urandom_range(0, 99) < 65);
         host_req   = ($urandom_range(0, 99) < 55);
         dma_write  = 1'($urandom_range(0, 1));
         host_write = 1'($urandom_range(0, 1));
         dma_addr   = ($urandom_range(0, 9) == 0) ? {32'($urandom), 32'($urandom_range(0, 255))} : 64'($urandom_range(0, 255));
         host_addr  = ($urandom_range(0, 9) == 0) ? {32'($urandom), 32'($urandom_range(0, 255))} : 64'($urandom_range(0, 255));
         dma_wdata  = $urandom;
         host_wdata = $urandom;
         step();
         n_cmp++;
         if (out_vec() !== exp_vec) begin n_bad++; $display("FAIL model_random cyc %0d: got %h expected %h", m_cyc, out_vec(), exp_vec); end
      end
      RESET = 0; dma_req = 0; host_req = 0;
   endtask

   initial begin
      RESET = 1; dma_req = 0; host_req = 0; dma_write = 0; host_write = 0;
      dma_addr = '0; host_addr = '0; dma_wdata = '0; host_wdata = '0; ram_data_in = '0;
      test_reset();
      test_dma_write_burst();
      test_host_read();
      test_tie_handover();
      test_burst_fairness();
      test_misaligned();
      test_reset_midburst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000ns");
      $fatal(1, "time bound exceeded");
   end

endmodule
